// File: rtl/nf_settings.sv
// Shared nanoFOX decode constants: major opcodes (instr[6:2]) and immediate formats.
package nf_settings;

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_type_e;

endpackage

// File: rtl/nf_i_predec.sv
// Combinational pre-decode of one instruction word: immediate, register-use flags, is_load.
// Zero latency, no handshake; instr[1:0] carries no decode information and is not taken.
module nf_i_predec
  import nf_settings::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:2] instr,
  output logic [XLEN-1:0] imm,
  output logic            uses_rs1,
  output logic            uses_rs2,
  output logic            is_load
);

  logic [4:0] opc;
  imm_type_e  imm_type;

  assign opc = instr[6:2];

  always_comb begin
    imm_type = IMM_NONE;
    case (opc)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: imm_type = IMM_I;
      OPC_STORE:                                  imm_type = IMM_S;
      OPC_BRANCH:                                 imm_type = IMM_B;
      OPC_LUI, OPC_AUIPC:                         imm_type = IMM_U;
      OPC_JAL:                                    imm_type = IMM_J;
      default:                                    imm_type = IMM_NONE;
    endcase
  end

  always_comb begin
    imm = '0;
    case (imm_type)
      IMM_I: imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      IMM_S: imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U: imm = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
      IMM_J: imm = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  assign uses_rs1 = !((opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL));
  assign uses_rs2 = (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
  assign is_load  = (opc == OPC_LOAD);

endmodule

// File: rtl/nf_i_du_q.sv
// Decode-side instruction queue with pre-decoded head and load-use scoreboard; head visible 1 cycle after push.
// in_rdy drops when full (no pop pass-through); head is held (out_vld=0, stall=1) while a source awaits a load.
module nf_i_du_q
  import nf_settings::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int RF_AW = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [XLEN-1:0]  in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [XLEN-1:0]  out_instr,
  output logic [XLEN-1:0]  out_pc,
  output logic [RF_AW-1:0] out_ra1,
  output logic [RF_AW-1:0] out_ra2,
  output logic [RF_AW-1:0] out_wa3,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_is_load,
  output logic             stall,
  input  logic             wb_vld,
  input  logic [RF_AW-1:0] wb_addr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0]       mem_instr [DEPTH];
  logic [XLEN-1:0]       mem_pc    [DEPTH];
  logic [PW-1:0]         rd_ptr, wr_ptr;
  logic [CW-1:0]         count;
  logic [2**RF_AW-1:0]   sb, sb_nxt;
  logic                  nonempty, hazard, push, pop;
  logic                  uses_rs1, uses_rs2;

  assign out_instr = mem_instr[rd_ptr];
  assign out_pc    = mem_pc[rd_ptr];
  assign out_ra1   = out_instr[19:15];
  assign out_ra2   = out_instr[24:20];
  assign out_wa3   = out_instr[11:7];

  nf_i_predec #(.XLEN(XLEN)) u_predec (
    .instr    (out_instr[XLEN-1:2]),
    .imm      (out_imm),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2),
    .is_load  (out_is_load)
  );

  // Hazard looks only at the registered scoreboard: a write-back releases the head next cycle.
  assign nonempty = (count != '0);
  assign hazard   = nonempty &
                    ((uses_rs1 & (out_ra1 != '0) & sb[out_ra1]) |
                     (uses_rs2 & (out_ra2 != '0) & sb[out_ra2]));
  assign in_rdy   = (count != CW'(DEPTH));
  assign out_vld  = nonempty & ~hazard & ~flush;
  assign stall    = nonempty & hazard;
  assign push     = in_vld & in_rdy & ~flush;
  assign pop      = out_vld & out_rdy;

  always_comb begin
    sb_nxt = sb;
    if (wb_vld)
      sb_nxt[wb_addr] = 1'b0;
    // Set after clear so a same-cycle set of the same register wins.
    if (pop && out_is_load && (out_wa3 != '0))
      sb_nxt[out_wa3] = 1'b1;
    sb_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr] <= in_instr;
      mem_pc[wr_ptr]    <= in_pc;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      sb     <= '0;
    end else begin
      // Scoreboard survives a flush: already-issued loads still write back.
      sb <= sb_nxt;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + PW'(1);
        if (pop)
          rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nf_i_du_q.sv
// Directed bench for nf_i_du_q: fill/drain, immediates, load-use stalls, flush, wrap-around.
module tb_nf_i_du_q;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        resetn, flush, in_vld, in_rdy, out_vld, out_rdy;
  logic [31:0] in_instr, in_pc, out_instr, out_pc, out_imm;
  logic [4:0]  out_ra1, out_ra2, out_wa3, wb_addr;
  logic        out_is_load, stall, wb_vld;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nf_i_du_q #(.DEPTH(4), .XLEN(32), .RF_AW(5)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_instr(in_instr), .in_pc(in_pc),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_instr(out_instr), .out_pc(out_pc),
    .out_ra1(out_ra1), .out_ra2(out_ra2), .out_wa3(out_wa3), .out_imm(out_imm),
    .out_is_load(out_is_load), .stall(stall), .wb_vld(wb_vld), .wb_addr(wb_addr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [31:0] instr, input logic [31:0] pc);
    in_vld = 1'b1; in_instr = instr; in_pc = pc;
    step();
    in_vld = 1'b0;
  endtask

  task automatic pop1();
    out_rdy = 1'b1;
    step();
    out_rdy = 1'b0;
  endtask

  logic [31:0] q[$];
  int          sent;

  initial begin
    resetn = 1'b0; flush = 1'b0; in_vld = 1'b0; out_rdy = 1'b0;
    in_instr = '0; in_pc = '0; wb_vld = 1'b0; wb_addr = '0;
    #1;
    chk("rst_in_rdy", in_rdy, 1);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_stall", stall, 0);
    step();
    resetn = 1'b1;

    // Fill to DEPTH with out_rdy low, offer a fifth, then drain.
    for (int i = 0; i < 4; i++) begin
      in_vld = 1'b1; in_instr = NOP; in_pc = 32'h100 + 32'(4 * i);
      step();
    end
    chk("full_in_rdy", in_rdy, 0);
    chk("full_head_pc", out_pc, 32'h100);
    in_pc = 32'h200;
    step();
    in_vld = 1'b0;
    chk("fifth_rdy", in_rdy, 0);
    out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_vld", out_vld, 1);
      chk("drain_pc", out_pc, 32'h100 + 32'(4 * i));
      step();
    end
    chk("drained_vld", out_vld, 0);
    chk("drained_rdy", in_rdy, 1);
    out_rdy = 1'b0;

    // Immediates across formats.
    push1(32'hFFF00093, 32'h10);
    chk("addi_imm", out_imm, 32'hFFFFFFFF);
    chk("addi_wa3", out_wa3, 1);
    chk("addi_ra1", out_ra1, 0);
    pop1();
    push1(32'h800000EF, 32'h14);
    chk("jal_imm", out_imm, 32'hFFF00000);
    pop1();
    push1(32'h12345037, 32'h18);
    chk("lui_imm", out_imm, 32'h12345000);
    pop1();
    push1(32'hFE20AE23, 32'h1C);
    chk("sw_imm", out_imm, 32'hFFFFFFFC);
    chk("sw_ra2", out_ra2, 2);
    pop1();
    push1(32'hFE208CE3, 32'h20);
    chk("beq_imm", out_imm, 32'hFFFFFFF8);
    pop1();
    push1(32'h0000000B, 32'h24);
    chk("none_imm", out_imm, 0);
    pop1();

    // Load-use: lw x2 then add x4,x2,x2.
    push1(32'h0000A103, 32'h30);
    push1(32'h00210233, 32'h34);
    chk("lw_is_load", out_is_load, 1);
    chk("lw_wa3", out_wa3, 2);
    out_rdy = 1'b1;
    step();
    chk("lu_stall", stall, 1);
    chk("lu_vld", out_vld, 0);
    chk("lu_pc", out_pc, 32'h34);
    step();
    chk("lu_stall_hold", stall, 1);
    wb_vld = 1'b1; wb_addr = 5'd2;
    #1;
    chk("lu_no_bypass", out_vld, 0);
    step();
    wb_vld = 1'b0;
    chk("lu_release_vld", out_vld, 1);
    chk("lu_release_stall", stall, 0);
    step();
    out_rdy = 1'b0;
    chk("lu_empty", out_vld, 0);

    // x0 destination and no-use source.
    push1(32'h0000A003, 32'h40);
    push1(32'h00000333, 32'h44);
    pop1();
    chk("x0_no_stall", stall, 0);
    chk("x0_vld", out_vld, 1);
    pop1();
    push1(32'h00002283, 32'h48);
    pop1();
    push1(32'h123452B7, 32'h4C);
    chk("lui_no_stall", stall, 0);
    chk("lui_vld", out_vld, 1);
    pop1();
    push1(32'h000283B3, 32'h50);
    chk("x5_stall", stall, 1);

    // Flush with three queued entries and an offered one.
    push1(NOP, 32'h54);
    push1(NOP, 32'h58);
    flush = 1'b1; in_vld = 1'b1; in_instr = NOP; in_pc = 32'h999;
    #1;
    chk("flush_vld", out_vld, 0);
    step();
    flush = 1'b0; in_vld = 1'b0;
    chk("flush_count", 32'(dut.count), 0);
    chk("flush_wr_ptr", 32'(dut.wr_ptr), 0);
    chk("flush_rd_ptr", 32'(dut.rd_ptr), 0);
    chk("flush_empty", out_vld, 0);
    chk("flush_no_stall", stall, 0);
    chk("flush_rdy", in_rdy, 1);
    push1(32'h000283B3, 32'h60);
    chk("flush_sb_kept", stall, 1);
    wb_vld = 1'b1; wb_addr = 5'd5;
    step();
    wb_vld = 1'b0;
    chk("x5_release", out_vld, 1);
    pop1();

    // Back-to-back push/pop with random ready; order checked against a queue.
    sent = 0;
    for (int cyc = 0; cyc < 100 && (sent < 10 || q.size() != 0); cyc++) begin
      in_vld   = (sent < 10);
      in_instr = NOP;
      in_pc    = 32'h400 + 32'(4 * sent);
      out_rdy  = (sent >= 10) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      chk("wrap_rdy", in_rdy, (q.size() != 4));
      chk("wrap_vld", out_vld, (q.size() != 0));
      if (out_vld && out_rdy && q.size() != 0) begin
        chk("wrap_pc", out_pc, q[0]);
        void'(q.pop_front());
      end
      if (in_vld && in_rdy) begin
        q.push_back(in_pc);
        sent++;
      end
      step();
    end
    in_vld = 1'b0; out_rdy = 1'b0;
    chk("wrap_done", ((sent == 10) && (q.size() == 0)), 1);

    // Same-cycle load pop to x3 and write-back to x3: set wins.
    push1(32'h00002183, 32'h70);
    chk("x3_pre", 32'(dut.sb[3]), 0);
    wb_vld = 1'b1; wb_addr = 5'd3; out_rdy = 1'b1;
    step();
    wb_vld = 1'b0; out_rdy = 1'b0;
    chk("x3_set_wins", 32'(dut.sb[3]), 1);
    push1(32'h00018433, 32'h74);
    chk("x3_stall", stall, 1);

    // Reset mid-operation drops entries and pending loads at once.
    #2;
    resetn = 1'b0;
    #1;
    chk("mid_rst_vld", out_vld, 0);
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_rdy", in_rdy, 1);
    chk("mid_rst_sb", dut.sb, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nf_i_du_q.md
Name: nf_i_du_q

Overview:
- Parametrised decode-side instruction queue for the nanoFOX pipeline; sits between the fetch unit and the execute stage.
- Buffers up to DEPTH fetched {pc, instr} pairs.
- Pre-decodes the head entry: register addresses, fully formed sign-extended immediate, and use flags.
- Holds the head with a load-use scoreboard until outstanding load write-backs complete.
- Adds elastic handshakes and hazard stalling to the existing purely combinational decode.

Parameters:
DEPTH, 4, queue entries (power of two, >=2)
XLEN, 32, instruction/pc/immediate width
RF_AW, 5, register file address width (scoreboard has 2**RF_AW bits)

Ports:
clk  in  1  core clock
resetn  in  1  asynchronous active-low reset
flush  in  1  discard all queued entries (branch/trap redirect)
in_vld  in  1  fetch offers an entry
in_rdy  out  1  queue can accept
in_instr  in  XLEN  instruction word
in_pc  in  XLEN  instruction address
out_vld  out  1  head entry valid and hazard-free
out_rdy  in  1  execute accepts head
out_instr  out  XLEN  head instruction
out_pc  out  XLEN  head pc
out_ra1  out  RF_AW  instr[19:15]
out_ra2  out  RF_AW  instr[24:20]
out_wa3  out  RF_AW  instr[11:7]
out_imm  out  XLEN  sign-extended immediate
out_is_load  out  1  head opcode is LOAD
stall  out  1  head valid but blocked by scoreboard
wb_vld  in  1  load write-back completes this cycle
wb_addr  in  RF_AW  destination register of that write-back

Behaviour:
- Storage: circular buffer with rd_ptr, wr_ptr and a count of width clog2(DEPTH)+1. Pointers wrap modulo DEPTH.
- Reset (resetn=0, asynchronous): pointers, count and scoreboard are cleared.
  - in_rdy=1, out_vld=0, stall=0.
  - Data outputs show entry[rd_ptr]; their value is don't-care while out_vld=0.
- Push when in_vld & in_rdy & ~flush.
  - in_rdy = (count != DEPTH). There is no same-cycle pop-to-push pass-through when full.
- Head data is combinational from stored entry[rd_ptr].
  - Latency: a push into an empty queue appears at the output the next cycle.
- Immediate, selected by opcode instr[6:2]:
  - I-type (LOAD 00000, OP_IMM 00100, JALR 11001, SYSTEM 11100): sext(instr[31:20]).
  - S-type (STORE 01000): sext({instr[31:25], instr[11:7]}).
  - B-type (BRANCH 11000): sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U-type (LUI 01101, AUIPC 00101): {instr[31:12], 12'b0}.
  - J-type (JAL 11011): sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - All other opcodes: 0.
- Use flags:
  - uses_rs1 is set for all opcodes except LUI, AUIPC and JAL.
  - uses_rs2 is set for OP (01100), STORE and BRANCH.
- hazard = head valid & ((uses_rs1 & ra1!=0 & sb[ra1]) | (uses_rs2 & ra2!=0 & sb[ra2])).
  - out_vld = (count!=0) & ~hazard & ~flush.
  - stall = (count!=0) & hazard.
  - No same-cycle bypass from wb_vld: hazard uses the registered scoreboard, so a matching write-back releases the head one cycle later.
- Pop when out_vld & out_rdy: rd_ptr advances and count decrements. Simultaneous push and pop leaves count unchanged.
- Scoreboard:
  - Set: on a pop with out_is_load and wa3!=0, sb[wa3] is set next cycle.
  - Clear: on wb_vld, sb[wb_addr] is cleared next cycle.
  - Set and clear of the same address in the same cycle: set wins.
  - sb[0] is never set.
- Flush wins over everything in its cycle:
  - No push, no pop, no scoreboard set; out_vld=0.
  - Next cycle: count=0 and rd_ptr=wr_ptr=0.
  - Scoreboard is NOT cleared, because issued loads still write back. wb_vld clears still apply during the flush cycle.
- Reset mid-operation drops all entries and pending loads immediately.

Decomposition:
- Add to nf_settings package:
  - opcode constants (LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, OP, OP_IMM, SYSTEM);
  - an imm_type_e enum (I, S, B, U, J, NONE).
- One sub-module, nf_i_predec: combinational decoder producing the immediate, use flags and is_load from an instruction word.
- Queue, scoreboard and handshake logic stay in nf_i_du_q.

Test Plan:
- Fill/drain, DEPTH=4, out_rdy=0: push 4 entries → in_rdy=0 after the 4th. A 5th in_vld is not accepted. Raise out_rdy → 4 pops in pc order with no gaps.
- Immediates: push 0xFFF00093 (addi x1,x0,-1) → out_imm=0xFFFFFFFF.
  - Push 0x800000EF (jal) → out_imm=0xFFF00000.
  - Push 0x12345037 (lui) → out_imm=0x12345000.
- Load-use: pop 0x0000A103 (lw x2,0(x1)) → sb[2] set.
  - Next head 0x00210233 (add x4,x2,x2) → stall=1, out_vld=0.
  - wb_vld=1, wb_addr=2 → out_vld=1 one cycle later.
- x0 and no-use: lw x0 followed by an add reading x0 → no stall. LUI x5 while sb[5]=1 → no stall.
- Flush with 3 queued entries and in_vld=1: next cycle count=0, the offered entry is dropped, and a pending sb bit stays set.
- Wrap-around and simultaneous events: 10 back-to-back push+pop cycles with random ready → order preserved.
  - Same-cycle load pop to x3 with wb_addr=3 → sb[3]=1 afterward.
